// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit WISC-subset processor.
// Holds opcode and R-format sub-op constants, the word width, and sign-extension helpers.
// Imported by the register file and the processor top level.
package proc_pkg;

  localparam int WORD_W = 16;

  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_NOP   = 5'b00001;
  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_LBI   = 5'b11000;
  localparam logic [4:0] OP_RTYPE = 5'b11011;
  localparam logic [4:0] OP_LD    = 5'b10001;
  localparam logic [4:0] OP_ST    = 5'b10000;
  localparam logic [4:0] OP_BEQZ  = 5'b01100;
  localparam logic [4:0] OP_BNEZ  = 5'b01101;
  localparam logic [4:0] OP_J     = 5'b00100;

  localparam logic [1:0] RF_ADD  = 2'b00;
  localparam logic [1:0] RF_SUB  = 2'b01;
  localparam logic [1:0] RF_XOR  = 2'b10;
  localparam logic [1:0] RF_ANDN = 2'b11;

  function automatic logic [WORD_W-1:0] sext5(input logic [4:0] v);
    return {{(WORD_W-5){v[4]}}, v};
  endfunction

  function automatic logic [WORD_W-1:0] sext8(input logic [7:0] v);
    return {{(WORD_W-8){v[7]}}, v};
  endfunction

  function automatic logic [WORD_W-1:0] sext11(input logic [10:0] v);
    return {{(WORD_W-11){v[10]}}, v};
  endfunction

endpackage

// File: rtl/proc_regfile.sv
// 8x16 register file: two combinational read ports, one synchronous write port.
// Ports: clk, rst (sync, active-high, clears all registers), addr_a/data_a and
// addr_b/data_b read ports, we/waddr/wdata write port. Reads return pre-write values.
module proc_regfile
  import proc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        addr_a,
  output logic [WORD_W-1:0] data_a,
  input  logic [2:0]        addr_b,
  output logic [WORD_W-1:0] data_b,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [WORD_W-1:0] wdata
);

  logic [WORD_W-1:0] regs [8];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // R0 is an ordinary register; no hardwired zero.
  assign data_a = regs[addr_a];
  assign data_b = regs[addr_b];

endmodule

// File: rtl/proc_hier_top.sv
// Single-cycle 16-bit WISC-subset processor: PC, register file, instruction and data memory, cycle counter.
// Ports: clk, rst (sync, active-high); trace outputs pc, inst, reg_write, write_reg, write_data,
// mem_write, mem_read, mem_addr, mem_data, halt, cycle_count. All outputs are combinational from state.
module proc_hier_top
  import proc_pkg::*;
#(
  parameter int    MEM_AW    = 10,
  // Name of the hex image the simulation environment places into imem (and dmem) at time 0.
  parameter string IMEM_FILE = "loadfile_all.img"
) (
  input  logic              clk,
  input  logic              rst,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] inst,
  output logic              reg_write,
  output logic [2:0]        write_reg,
  output logic [WORD_W-1:0] write_data,
  output logic              mem_write,
  output logic              mem_read,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_data,
  output logic              halt,
  output logic [31:0]       cycle_count
);

  // Word-organised memories, indexed by byte address bits [MEM_AW:1].
  logic [WORD_W-1:0] imem [2**MEM_AW];
  logic [WORD_W-1:0] dmem [2**MEM_AW];

  logic [WORD_W-1:0] pc_q;
  logic              halted_q;
  logic [31:0]       cyc_q;

  logic [4:0]        opcode;
  logic [WORD_W-1:0] rs_val;
  logic [WORD_W-1:0] rt_val;
  logic [WORD_W-1:0] pc_inc;
  logic [WORD_W-1:0] ld_val;

  logic [WORD_W-1:0] alu;
  logic [WORD_W-1:0] next_pc;
  logic [2:0]        wsel;
  logic              wr_en;
  logic              is_st;
  logic              is_ld;
  logic              is_halt;
  logic              stopped;

  assign inst   = imem[pc_q[MEM_AW:1]];
  assign opcode = inst[15:11];
  assign pc_inc = pc_q + 16'd2;
  assign ld_val = dmem[alu[MEM_AW:1]];

  // Port B always reads inst[7:5]: Rt for R-format and the store source for ST.
  proc_regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .addr_a (inst[10:8]),
    .data_a (rs_val),
    .addr_b (inst[7:5]),
    .data_b (rt_val),
    .we     (reg_write),
    .waddr  (write_reg),
    .wdata  (write_data)
  );

  always_comb begin
    alu     = rs_val + sext5(inst[4:0]);
    next_pc = pc_inc;
    wsel    = inst[7:5];
    wr_en   = 1'b0;
    is_st   = 1'b0;
    is_ld   = 1'b0;
    is_halt = 1'b0;
    case (opcode)
      OP_HALT:  is_halt = 1'b1;
      OP_ADDI:  wr_en = 1'b1;
      OP_LBI: begin
        alu   = sext8(inst[7:0]);
        wsel  = inst[10:8];
        wr_en = 1'b1;
      end
      OP_RTYPE: begin
        wsel  = inst[4:2];
        wr_en = 1'b1;
        case (inst[1:0])
          RF_ADD:  alu = rs_val + rt_val;
          RF_SUB:  alu = rt_val - rs_val;
          RF_XOR:  alu = rs_val ^ rt_val;
          RF_ANDN: alu = rs_val & ~rt_val;
          default: alu = rs_val + rt_val;
        endcase
      end
      OP_LD: begin
        is_ld = 1'b1;
        wr_en = 1'b1;
      end
      OP_ST:    is_st = 1'b1;
      OP_BEQZ:  if (rs_val == '0) next_pc = pc_inc + sext8(inst[7:0]);
      OP_BNEZ:  if (rs_val != '0) next_pc = pc_inc + sext8(inst[7:0]);
      OP_J:     next_pc = pc_inc + sext11(inst[10:0]);
      default: ;
    endcase
  end

  // Once halted, nothing commits and the pc holds until reset; reset masks everything.
  assign stopped     = is_halt | halted_q;
  assign reg_write   = wr_en & ~stopped & ~rst;
  assign mem_write   = is_st & ~stopped & ~rst;
  assign mem_read    = ~mem_write;
  assign halt        = stopped & ~rst;
  assign write_reg   = wsel;
  assign write_data  = is_ld ? ld_val : alu;
  assign mem_addr    = alu;
  assign mem_data    = rt_val;
  assign pc          = pc_q;
  assign cycle_count = cyc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= '0;
      halted_q <= 1'b0;
      cyc_q    <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (!stopped) pc_q <= next_pc;
      if (is_halt) halted_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_write) dmem[alu[MEM_AW:1]] <= rt_val;
  end

endmodule

// File: tb/tb_proc_hier_top.sv
// Directed trace bench for proc_hier_top: small programs are placed in instruction memory,
// the processor is reset, and per-cycle trace outputs are compared with hand-computed values.
module tb_proc_hier_top;
  import proc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc, inst, write_data, mem_addr, mem_data;
  logic        reg_write, mem_write, mem_read, halt;
  logic [2:0]  write_reg;
  logic [31:0] cycle_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  proc_hier_top dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .inst        (inst),
    .reg_write   (reg_write),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .mem_write   (mem_write),
    .mem_read    (mem_read),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .halt        (halt),
    .cycle_count (cycle_count)
  );

  typedef struct {
    int          prog;   // >=0: load this program and reset first; -1: advance one cycle
    logic [15:0] pc;
    logic        rw;
    logic [2:0]  wreg;
    logic [15:0] wdata;
    logic        mw;
    logic        chk_mem;
    logic [15:0] maddr;
    logic [15:0] mdata;
    logic        hlt;
    logic [31:0] cyc;
  } vec_t;

  vec_t        vt[$];
  logic [15:0] progs [5][16];

  function automatic logic [15:0] enc_i(input logic [4:0] op, input logic [2:0] rs,
                                         input logic [2:0] rd, input logic [4:0] imm);
    return {op, rs, rd, imm};
  endfunction

  function automatic logic [15:0] enc_b(input logic [4:0] op, input logic [2:0] rs,
                                         input logic [7:0] imm);
    return {op, rs, imm};
  endfunction

  function automatic logic [15:0] enc_r(input logic [2:0] rs, input logic [2:0] rt,
                                         input logic [2:0] rd, input logic [1:0] sub);
    return {OP_RTYPE, rs, rt, rd, sub};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic addv(input int p, input logic [15:0] epc, input logic rw, input logic [2:0] wr,
                      input logic [15:0] wd, input logic mw, input logic cm,
                      input logic [15:0] ma, input logic [15:0] md, input logic h,
                      input logic [31:0] c);
    vec_t v;
    v.prog = p; v.pc = epc; v.rw = rw; v.wreg = wr; v.wdata = wd; v.mw = mw;
    v.chk_mem = cm; v.maddr = ma; v.mdata = md; v.hlt = h; v.cyc = c;
    vt.push_back(v);
  endtask

  // Holds reset for two edges while the program is written, checks reset outputs, releases.
  task automatic load_and_reset(input int p);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) dut.imem[i] = progs[p][i];
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk($sformatf("reset p%0d pc", p), {16'h0, pc}, 32'h0);
    chk($sformatf("reset p%0d reg_write", p), {31'h0, reg_write}, 32'h0);
    chk($sformatf("reset p%0d mem_write", p), {31'h0, mem_write}, 32'h0);
    chk($sformatf("reset p%0d halt", p), {31'h0, halt}, 32'h0);
    chk($sformatf("reset p%0d cycle_count", p), cycle_count, 32'h0);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    for (int p = 0; p < 5; p++)
      for (int i = 0; i < 16; i++) progs[p][i] = 16'h0000;

    // P0: LBI R1,5; HALT
    progs[0][0] = enc_b(OP_LBI, 3'd1, 8'h05);
    // P1: arithmetic, store/load, R-format ops, then HALT at 0x12
    progs[1][0] = enc_i(OP_ADDI, 3'd1, 3'd2, 5'h1F);
    progs[1][1] = enc_r(3'd1, 3'd2, 3'd3, RF_SUB);
    progs[1][2] = enc_b(OP_LBI, 3'd1, 8'h10);
    progs[1][3] = enc_b(OP_LBI, 3'd2, 8'h7F);
    progs[1][4] = enc_i(OP_ST, 3'd1, 3'd2, 5'd2);
    progs[1][5] = enc_i(OP_LD, 3'd1, 3'd4, 5'd2);
    progs[1][6] = enc_r(3'd1, 3'd2, 3'd5, RF_ADD);
    progs[1][7] = enc_r(3'd1, 3'd2, 3'd6, RF_XOR);
    progs[1][8] = enc_r(3'd3, 3'd2, 3'd7, RF_ANDN);
    // P2/P3: four NOPs, then BEQZ/BNEZ R0,+4 at 0x0008, HALT elsewhere
    // P4: NOP, NOP, J -2 at 0x0004
    for (int i = 0; i < 4; i++) begin
      progs[2][i] = 16'h0800;
      progs[3][i] = 16'h0800;
    end
    progs[2][4] = enc_b(OP_BEQZ, 3'd0, 8'd4);
    progs[3][4] = enc_b(OP_BNEZ, 3'd0, 8'd4);
    progs[4][0] = 16'h0800;
    progs[4][1] = 16'h0800;
    progs[4][2] = {OP_J, 11'h7FE};

    //    prog pc      rw wr wdata     mw cm maddr    mdata    h  cyc
    addv(0, 16'h0000, 1, 1, 16'h0005, 0, 0, 16'h0,   16'h0,   0, 0);
    addv(-1, 16'h0002, 0, 0, 16'h0,   0, 0, 16'h0,   16'h0,   1, 1);
    addv(-1, 16'h0002, 0, 0, 16'h0,   0, 0, 16'h0,   16'h0,   1, 2);
    addv(-1, 16'h0002, 0, 0, 16'h0,   0, 0, 16'h0,   16'h0,   1, 3);
    addv(1, 16'h0000, 1, 2, 16'hFFFF, 0, 0, 16'h0,   16'h0,   0, 0);
    addv(-1, 16'h0002, 1, 3, 16'hFFFF, 0, 0, 16'h0,   16'h0,   0, 1);
    addv(-1, 16'h0004, 1, 1, 16'h0010, 0, 0, 16'h0,   16'h0,   0, 2);
    addv(-1, 16'h0006, 1, 2, 16'h007F, 0, 0, 16'h0,   16'h0,   0, 3);
    addv(-1, 16'h0008, 0, 0, 16'h0,   1, 1, 16'h0012, 16'h007F, 0, 4);
    addv(-1, 16'h000A, 1, 4, 16'h007F, 0, 1, 16'h0012, 16'h0,   0, 5);
    addv(-1, 16'h000C, 1, 5, 16'h008F, 0, 0, 16'h0,   16'h0,   0, 6);
    addv(-1, 16'h000E, 1, 6, 16'h006F, 0, 0, 16'h0,   16'h0,   0, 7);
    addv(-1, 16'h0010, 1, 7, 16'hFF80, 0, 0, 16'h0,   16'h0,   0, 8);
    addv(-1, 16'h0012, 0, 0, 16'h0,   0, 0, 16'h0,   16'h0,   1, 9);
    addv(-1, 16'h0012, 0, 0, 16'h0,   0, 0, 16'h0,   16'h0,   1, 10);
    for (int p = 2; p < 4; p++) begin
      addv(p, 16'h0000, 0, 0, 16'h0,  0, 0, 16'h0,   16'h0,   0, 0);
      addv(-1, 16'h0002, 0, 0, 16'h0, 0, 0, 16'h0,   16'h0,   0, 1);
      addv(-1, 16'h0004, 0, 0, 16'h0, 0, 0, 16'h0,   16'h0,   0, 2);
      addv(-1, 16'h0006, 0, 0, 16'h0, 0, 0, 16'h0,   16'h0,   0, 3);
      addv(-1, 16'h0008, 0, 0, 16'h0, 0, 0, 16'h0,   16'h0,   0, 4);
      addv(-1, (p == 2) ? 16'h000E : 16'h000A, 0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 1, 5);
    end

    foreach (vt[i]) begin
      if (vt[i].prog >= 0) load_and_reset(vt[i].prog);
      else @(negedge clk);
      chk($sformatf("v%0d pc", i), {16'h0, pc}, {16'h0, vt[i].pc});
      chk($sformatf("v%0d reg_write", i), {31'h0, reg_write}, {31'h0, vt[i].rw});
      chk($sformatf("v%0d mem_write", i), {31'h0, mem_write}, {31'h0, vt[i].mw});
      chk($sformatf("v%0d mem_read", i), {31'h0, mem_read}, {31'h0, ~vt[i].mw});
      chk($sformatf("v%0d halt", i), {31'h0, halt}, {31'h0, vt[i].hlt});
      chk($sformatf("v%0d cycle_count", i), cycle_count, vt[i].cyc);
      if (vt[i].rw) begin
        chk($sformatf("v%0d write_reg", i), {29'h0, write_reg}, {29'h0, vt[i].wreg});
        chk($sformatf("v%0d write_data", i), {16'h0, write_data}, {16'h0, vt[i].wdata});
      end
      if (vt[i].chk_mem) chk($sformatf("v%0d mem_addr", i), {16'h0, mem_addr}, {16'h0, vt[i].maddr});
      if (vt[i].mw) chk($sformatf("v%0d mem_data", i), {16'h0, mem_data}, {16'h0, vt[i].mdata});
    end

    // J -2 self-loop, then a one-cycle reset mid-run.
    load_and_reset(4);
    repeat (4) @(negedge clk);
    chk("jloop pc", {16'h0, pc}, 32'h0004);
    chk("jloop cycle_count", cycle_count, 32'd4);
    @(negedge clk);
    chk("jloop pc held", {16'h0, pc}, 32'h0004);
    rst = 1'b1;
    #1;
    chk("jloop rst reg_write", {31'h0, reg_write}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("jloop after rst pc", {16'h0, pc}, 32'h0);
    chk("jloop after rst cycle_count", cycle_count, 32'h0);

    // Halted, then reset asserted on the HALT cycle: reset masks halt and clears the flag.
    load_and_reset(0);
    repeat (3) @(negedge clk);
    chk("halted halt", {31'h0, halt}, 32'h1);
    chk("halted cycle_count", cycle_count, 32'd3);
    rst = 1'b1;
    #1;
    chk("halt+rst halt", {31'h0, halt}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-halt rst pc", {16'h0, pc}, 32'h0);
    chk("post-halt rst reg_write", {31'h0, reg_write}, 32'h1);
    chk("post-halt rst write_data", {16'h0, write_data}, 32'h0005);
    @(negedge clk);
    chk("post-halt rst pc advance", {16'h0, pc}, 32'h0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
